thread_pc_sequencer: RTL

Per-thread program counter sequencer for the barrel-threaded datapath, directly downstream of the branch module. Each cycle it selects the next thread in round-robin order and computes that thread's next PC from four sources: the branch module's `jump`/`destination` result, the I/O-ready replay condition, a memory-mapped PC overwrite, or a plain increment. It registers and issues the resulting `pc_out` with its thread index to instruction fetch. `cancel` from the branch module is not consumed here; it goes to the write-enable logic.

---
 rtl/thread_pc_sequencer_pkg.sv | 25 ++
 rtl/thread_round_robin_counter.sv | 22 ++
 rtl/thread_pc_sequencer.sv | 101 ++++++++++
 3 files changed

// File: rtl/thread_pc_sequencer_pkg.sv
// Shared definitions for the per-thread PC sequencer: next-PC source
// selection and config address decoding helpers.
package thread_pc_sequencer_pkg;

    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_REPLAY = 2'd1,
        SEL_JUMP   = 2'd2,
        SEL_INCR   = 2'd3
    } pc_sel_e;

    // Slot index relative to the base of the config window; only meaningful
    // when config_slot_hit() is true.
    function automatic logic [31:0] config_slot_offset(input logic [31:0] addr,
                                                       input logic [31:0] base);
        return addr - base;
    endfunction

    function automatic logic config_slot_hit(input logic [31:0] addr,
                                             input logic [31:0] base,
                                             input logic [31:0] count);
        return (addr >= base) && ((addr - base) < count);
    endfunction

endpackage

// File: rtl/thread_round_robin_counter.sv
// Mod-COUNT thread counter with synchronous reset; selects the thread whose
// PC is computed each cycle.
module thread_round_robin_counter #(
    parameter int unsigned COUNT = 8,
    parameter int unsigned WIDTH = 3
) (
    input  logic             clock,
    input  logic             reset,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
        end else if (count == WIDTH'(COUNT - 1)) begin
            count <= '0;
        end else begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/thread_pc_sequencer.sv
// Per-thread program counter sequencer: round-robin thread selection, next-PC
// choice (hold / replay / jump / increment) and memory-mapped PC overwrite.
module thread_pc_sequencer
    import thread_pc_sequencer_pkg::*;
#(
    parameter int unsigned WORD_WIDTH         = 36,
    parameter int unsigned ADDR_WIDTH         = 10,
    parameter int unsigned PC_WIDTH           = 10,
    parameter int unsigned THREAD_COUNT       = 8,
    parameter int unsigned THREAD_COUNT_WIDTH = 3,
    parameter int unsigned START_PC           = 0,
    parameter int unsigned CONFIG_ADDR_BASE   = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          config_wren,
    input  logic [ADDR_WIDTH-1:0]         config_addr,
    input  logic [WORD_WIDTH-1:0]         config_data,
    input  logic                          jump,
    input  logic [PC_WIDTH-1:0]           destination,
    input  logic                          io_ready,
    output logic [THREAD_COUNT_WIDTH-1:0] current_thread,
    output logic [PC_WIDTH-1:0]           pc_out,
    output logic [THREAD_COUNT_WIDTH-1:0] thread_out
);

    logic [THREAD_COUNT_WIDTH-1:0] tc;
    logic [PC_WIDTH-1:0]           pc_mem [THREAD_COUNT];
    logic                          hold   [THREAD_COUNT];

    pc_sel_e                       sel;
    logic [PC_WIDTH-1:0]           cur_pc;
    logic [PC_WIDTH-1:0]           next_pc;

    logic [31:0]                   cfg_offset;
    logic                          cfg_hit;
    logic [THREAD_COUNT_WIDTH-1:0] cfg_slot;
    logic                          unused_bits;

    thread_round_robin_counter #(
        .COUNT (THREAD_COUNT),
        .WIDTH (THREAD_COUNT_WIDTH)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .count (tc)
    );

    assign current_thread = tc;

    assign cfg_offset  = config_slot_offset(32'(config_addr), 32'(CONFIG_ADDR_BASE));
    assign cfg_hit     = config_wren &&
                         config_slot_hit(32'(config_addr), 32'(CONFIG_ADDR_BASE), 32'(THREAD_COUNT));
    assign cfg_slot    = cfg_offset[THREAD_COUNT_WIDTH-1:0];
    assign unused_bits = ^{cfg_offset[31:THREAD_COUNT_WIDTH], config_data[WORD_WIDTH-1:PC_WIDTH]};

    assign cur_pc = pc_mem[tc];

    always_comb begin
        sel = SEL_INCR;
        if (hold[tc]) begin
            sel = SEL_HOLD;
        end else if (!io_ready) begin
            sel = SEL_REPLAY;
        end else if (jump) begin
            sel = SEL_JUMP;
        end
    end

    always_comb begin
        next_pc = cur_pc + PC_WIDTH'(1);
        case (sel)
            SEL_HOLD, SEL_REPLAY: next_pc = cur_pc;
            SEL_JUMP:             next_pc = destination;
            default:              next_pc = cur_pc + PC_WIDTH'(1);
        endcase
    end

    // The config write comes after the issue update so that a same-cycle
    // write to the current thread wins over the issued value.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < THREAD_COUNT; i++) begin
                pc_mem[i] <= PC_WIDTH'(START_PC);
                hold[i]   <= 1'b1;
            end
            pc_out     <= PC_WIDTH'(START_PC);
            thread_out <= '0;
        end else begin
            pc_mem[tc] <= next_pc;
            hold[tc]   <= 1'b0;
            pc_out     <= next_pc;
            thread_out <= tc;
            if (cfg_hit) begin
                pc_mem[cfg_slot] <= config_data[PC_WIDTH-1:0];
                hold[cfg_slot]   <= 1'b1;
            end
        end
    end

endmodule
